srec_emitter: RTL and testbench
===============================

Name: srec_emitter

Overview:
- Memory-to-text dumper; runs in the opposite direction to the S-record loader.
- On a rising edge of dumpEnable, reads dumpLength bytes from the byte-addressable memory, one byte at a time, starting at dumpStartAddr.
- Emits them as Motorola S3 records, one ASCII character per handshake, followed by one S7 termination record.
- Used to dump memory images after simulation/test for comparison against golden .srec files.

Parameters:
- BYTES_PER_REC, 16, data bytes per S3 record; legal 1..32.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dumpEnable  in  1  rising edge starts a dump; ignored while dumpBusy=1.
- dumpStartAddr  in  32  first byte address; sampled at start.
- dumpLength  in  32  byte count; sampled at start; 0 is legal.
- dumpEntryAddr  in  32  address field of the S7 record; sampled at start.
- memAddr  out  32  byte read address.
- memAccessSize  out  2  always 2'b00 (byte access).
- memReadEn  out  1  one-cycle read strobe.
- memData  in  32  read data; byte in bits [7:0]; valid exactly one cycle after memReadEn.
- charOut  out  8  ASCII character.
- charValid  out  1  charOut holds a character.
- charReady  in  1  sink accepts the character when charValid=1 and charReady=1.
- dumpBusy  out  1  dump in progress.
- dumpDone  out  1  sticky completion flag.

Behaviour:
- Reset (asynchronous, immediate): all outputs 0; state IDLE; dumpEnable edge-detect register cleared. Reset mid-dump abandons the dump with no further characters.
- Start: registered edge detect on dumpEnable. In the cycle after the edge is seen, sample inputs, set dumpBusy=1, clear dumpDone.
- Record format (hex digits uppercase, ASCII 0-9 / A-F):
  - S3 record: 'S' '3' CC AAAAAAAA DD... KK LF (8'h0A).
  - CC = N+5, where N = min(BYTES_PER_REC, remaining bytes).
  - KK = ~(CC + four address bytes + data bytes) mod 256.
  - Hex values are sent most-significant nibble first.
- States: IDLE, S_CHAR, TYPE, COUNT(2 nibbles), ADDR(8), FETCH, WAIT, DATA(2), CSUM(2), EOL, TERM_S, TERM_TYPE, TERM_COUNT, TERM_ADDR, TERM_CSUM, TERM_EOL, DONE.
- Sequencing:
  - After each S3 EOL: if remaining>0, next S3 record; else TERM_S.
  - TERM_* emits "S705" + dumpEntryAddr + KK + LF, with KK = ~(05 + four entry bytes).
- Data path per byte:
  - FETCH: memReadEn=1, memAddr=current address; no character offered.
  - WAIT: capture memData[7:0] and add it to the checksum.
  - DATA: offers two characters.
  - Cost: 2 bubble cycles per byte.
- Handshake:
  - Every character-emitting state holds charValid=1 and charOut stable until accepted, then advances in the same cycle.
  - Other states drive charValid=0.
  - With charReady held high: record time = 15+4N cycles; S7 record = 15 cycles.
- Arithmetic:
  - Address increments by 1 per byte, modulo 2^32; wrap is permitted, and a record's address field is the address of its first byte.
  - Remaining count decrements by N per record.
  - Checksum is an 8-bit accumulator cleared at the start of each record.
- dumpLength=0: only the S7 record is emitted.
- Completion: after the final LF is accepted, enter DONE: dumpBusy=0, dumpDone=1; dumpDone holds until the next start or reset.
- dumpEnable edges while busy are ignored; a new edge from DONE restarts the dump.

Decomposition:
- srec_pkg holds: state enum; ASCII constants ('S'=8'h53, '3'=8'h33, '7'=8'h37, LF=8'h0A); S7 count 8'h05; function nibble_to_ascii(4b)->8b.
- No sub-module; single FSM with nibble index counter, byte counter, address register, checksum accumulator.

Test Plan:
- Single record: start 0x00000000, len 4, mem 01 02 03 04, entry 0, charReady=1 -> "S3090000000001020304EC\n" then "S70500000000FA\n", dumpDone=1, 4 memReadEn pulses at addr 0..3, 31+15 cycles of character/bubble activity.
- Record split: BYTES_PER_REC=16, start 0x00001000, len 20 -> first record count 0x15 @00001000 (16 bytes), second count 0x09 @00001010 (4 bytes), then S7; checksums match a reference model.
- Length zero: len 0, entry 0x80020000 -> only "S7058002000078\n"; no memReadEn.
- Backpressure: charReady low for 3 cycles during ADDR, and randomly toggled during DATA -> charOut/charValid stable while stalled; output stream identical to the unstalled run.
- Wrap: start 0xFFFFFFFE, len 4 -> reads FFFFFFFE, FFFFFFFF, 00000000, 00000001; single record address field FFFFFFFE.
- Reset/retrigger: assert reset_n low mid-DATA -> all outputs 0 immediately; dumpEnable edge while busy -> ignored; fresh edge after reset -> complete correct dump from the start.

Source files
------------

// File: rtl/srec_emitter_pkg.sv
// Shared types, ASCII constants and helpers for the S-record emitter.
// Turns memory contents into Motorola S3 data records plus an S7 trailer.
package srec_emitter_pkg;

  typedef enum logic [4:0] {
    IDLE, S_CHAR, TYPE, COUNT, ADDR, FETCH, WAIT, DATA, CSUM, EOL,
    TERM_S, TERM_TYPE, TERM_COUNT, TERM_ADDR, TERM_CSUM, TERM_EOL, DONE
  } state_t;

  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_3  = 8'h33;
  localparam logic [7:0] ASCII_7  = 8'h37;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] S7_COUNT = 8'h05;

  // Digits map from '0' (0x30); A-F map from 'A' - 10 (0x37).
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] byte_sum(input logic [31:0] w);
    return w[31:24] + w[23:16] + w[15:8] + w[7:0];
  endfunction

endpackage

// File: rtl/srec_emitter_if.sv
// Memory read bus and character stream of the S-record emitter.
interface srec_emitter_if;
  logic [31:0] memAddr;
  logic [1:0]  memAccessSize;
  logic        memReadEn;
  logic [31:0] memData;
  logic [7:0]  charOut;
  logic        charValid;
  logic        charReady;

  modport master (
    output memAddr, memAccessSize, memReadEn, charOut, charValid,
    input  memData, charReady
  );

  modport slave (
    input  memAddr, memAccessSize, memReadEn, charOut, charValid,
    output memData, charReady
  );
endinterface

// File: rtl/srec_emitter.sv
// Dumps a memory range as S3 records followed by an S7 trailer, one ASCII
// character per handshake, reading one byte per FETCH/WAIT pair.
module srec_emitter
  import srec_emitter_pkg::*;
#(
  parameter int BYTES_PER_REC = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        dumpEnable,
  input  logic [31:0] dumpStartAddr,
  input  logic [31:0] dumpLength,
  input  logic [31:0] dumpEntryAddr,
  output logic        dumpBusy,
  output logic        dumpDone,
  srec_emitter_if.master bus
);

  localparam logic [31:0] BPR32 = 32'(BYTES_PER_REC);
  localparam logic [5:0]  BPR6  = 6'(BYTES_PER_REC);

  state_t      r_state;
  logic        r_enPrev;
  logic [31:0] r_addr;
  logic [31:0] r_remain;
  logic [31:0] r_entry;
  logic [5:0]  r_recN;
  logic [5:0]  r_cnt;
  logic [2:0]  r_nib;
  logic [7:0]  r_csum;
  logic [7:0]  r_data;
  logic [31:0] r_memAddr;
  logic        r_memReadEn;
  logic [7:0]  r_charOut;
  logic        r_charValid;
  logic        r_busy;
  logic        r_done;

  logic        w_idle;
  logic        w_rise;
  logic        w_fire;
  logic        w_recStart;
  logic [31:0] w_srcAddr;
  logic [31:0] w_srcRemain;
  logic [31:0] w_srcEntry;
  logic [5:0]  w_recN;
  logic [7:0]  w_recCC;
  logic [7:0]  w_recSum;
  logic [7:0]  w_termSum;
  logic [7:0]  w_cc;
  logic [7:0]  w_csumOut;
  logic [2:0]  w_nextNib;
  logic [31:0] w_field;
  logic [3:0]  w_fieldNib;
  logic [31:0] w_addrNext;
  logic [5:0]  w_cntNext;
  logic        w_unusedHi;

  assign w_idle     = (r_state == IDLE) || (r_state == DONE);
  assign w_rise     = dumpEnable && !r_enPrev;
  assign w_fire     = r_charValid && bus.charReady;
  assign w_recStart = (w_idle && w_rise) || ((r_state == EOL) && w_fire);

  // A new record is set up either from the start inputs or from the running registers.
  assign w_srcAddr   = w_idle ? dumpStartAddr : r_addr;
  assign w_srcRemain = w_idle ? dumpLength    : r_remain;
  assign w_srcEntry  = w_idle ? dumpEntryAddr : r_entry;
  assign w_recN      = (w_srcRemain < BPR32) ? w_srcRemain[5:0] : BPR6;
  assign w_recCC     = {2'b00, w_recN} + 8'd5;
  assign w_recSum    = w_recCC + byte_sum(w_srcAddr);
  assign w_termSum   = S7_COUNT + byte_sum(w_srcEntry);

  assign w_cc       = {2'b00, r_recN} + 8'd5;
  assign w_csumOut  = ~r_csum;
  assign w_nextNib  = r_nib + 3'd1;
  assign w_field    = (r_state == TERM_ADDR) ? r_entry : r_addr;
  assign w_fieldNib = 4'(w_field >> (5'd28 - {w_nextNib, 2'b00}));
  assign w_addrNext = r_addr + 32'd1;
  assign w_cntNext  = r_cnt + 6'd1;
  assign w_unusedHi = ^bus.memData[31:8];

  assign bus.memAddr       = r_memAddr;
  assign bus.memAccessSize = 2'b00;
  assign bus.memReadEn     = r_memReadEn;
  assign bus.charOut       = r_charOut;
  assign bus.charValid     = r_charValid;
  assign dumpBusy          = r_busy;
  assign dumpDone          = r_done;

  // Outputs are loaded on each transition, so the next character is ready as soon as one is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_enPrev    <= 1'b0;
      r_addr      <= '0;
      r_remain    <= '0;
      r_entry     <= '0;
      r_recN      <= '0;
      r_cnt       <= '0;
      r_nib       <= '0;
      r_csum      <= '0;
      r_data      <= '0;
      r_memAddr   <= '0;
      r_memReadEn <= 1'b0;
      r_charOut   <= '0;
      r_charValid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_enPrev <= dumpEnable;
      if (w_recStart) begin
        if (w_idle) begin
          r_addr   <= dumpStartAddr;
          r_remain <= dumpLength;
          r_entry  <= dumpEntryAddr;
          r_busy   <= 1'b1;
          r_done   <= 1'b0;
        end
        r_charOut   <= ASCII_S;
        r_charValid <= 1'b1;
        r_cnt       <= '0;
        r_nib       <= '0;
        if (w_srcRemain != 32'd0) begin
          r_state <= S_CHAR;
          r_recN  <= w_recN;
          r_csum  <= w_recSum;
        end else begin
          r_state <= TERM_S;
          r_csum  <= w_termSum;
        end
      end else begin
        case (r_state)
          S_CHAR: if (w_fire) begin
            r_state   <= TYPE;
            r_charOut <= ASCII_3;
          end
          TYPE: if (w_fire) begin
            r_state   <= COUNT;
            r_nib     <= '0;
            r_charOut <= nibble_to_ascii(w_cc[7:4]);
          end
          COUNT: if (w_fire) begin
            if (r_nib == 3'd0) begin
              r_nib     <= 3'd1;
              r_charOut <= nibble_to_ascii(w_cc[3:0]);
            end else begin
              r_state   <= ADDR;
              r_nib     <= '0;
              r_charOut <= nibble_to_ascii(r_addr[31:28]);
            end
          end
          ADDR: if (w_fire) begin
            if (r_nib != 3'd7) begin
              r_nib     <= w_nextNib;
              r_charOut <= nibble_to_ascii(w_fieldNib);
            end else begin
              r_state     <= FETCH;
              r_charValid <= 1'b0;
              r_memReadEn <= 1'b1;
              r_memAddr   <= r_addr;
            end
          end
          FETCH: begin
            r_memReadEn <= 1'b0;
            r_state     <= WAIT;
          end
          WAIT: begin
            r_data      <= bus.memData[7:0];
            r_csum      <= r_csum + bus.memData[7:0];
            r_nib       <= '0;
            r_charOut   <= nibble_to_ascii(bus.memData[7:4]);
            r_charValid <= 1'b1;
            r_state     <= DATA;
          end
          DATA: if (w_fire) begin
            if (r_nib == 3'd0) begin
              r_nib     <= 3'd1;
              r_charOut <= nibble_to_ascii(r_data[3:0]);
            end else begin
              r_addr   <= w_addrNext;
              r_remain <= r_remain - 32'd1;
              r_cnt    <= w_cntNext;
              r_nib    <= '0;
              if (w_cntNext == r_recN) begin
                r_state   <= CSUM;
                r_charOut <= nibble_to_ascii(w_csumOut[7:4]);
              end else begin
                r_state     <= FETCH;
                r_charValid <= 1'b0;
                r_memReadEn <= 1'b1;
                r_memAddr   <= w_addrNext;
              end
            end
          end
          CSUM: if (w_fire) begin
            if (r_nib == 3'd0) begin
              r_nib     <= 3'd1;
              r_charOut <= nibble_to_ascii(w_csumOut[3:0]);
            end else begin
              r_state   <= EOL;
              r_charOut <= ASCII_LF;
            end
          end
          TERM_S: if (w_fire) begin
            r_state   <= TERM_TYPE;
            r_charOut <= ASCII_7;
          end
          TERM_TYPE: if (w_fire) begin
            r_state   <= TERM_COUNT;
            r_nib     <= '0;
            r_charOut <= nibble_to_ascii(S7_COUNT[7:4]);
          end
          TERM_COUNT: if (w_fire) begin
            if (r_nib == 3'd0) begin
              r_nib     <= 3'd1;
              r_charOut <= nibble_to_ascii(S7_COUNT[3:0]);
            end else begin
              r_state   <= TERM_ADDR;
              r_nib     <= '0;
              r_charOut <= nibble_to_ascii(r_entry[31:28]);
            end
          end
          TERM_ADDR: if (w_fire) begin
            if (r_nib != 3'd7) begin
              r_nib     <= w_nextNib;
              r_charOut <= nibble_to_ascii(w_fieldNib);
            end else begin
              r_state   <= TERM_CSUM;
              r_nib     <= '0;
              r_charOut <= nibble_to_ascii(w_csumOut[7:4]);
            end
          end
          TERM_CSUM: if (w_fire) begin
            if (r_nib == 3'd0) begin
              r_nib     <= 3'd1;
              r_charOut <= nibble_to_ascii(w_csumOut[3:0]);
            end else begin
              r_state   <= TERM_EOL;
              r_charOut <= ASCII_LF;
            end
          end
          TERM_EOL: if (w_fire) begin
            r_state     <= DONE;
            r_charValid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_srec_emitter.sv
// Scoreboard bench for srec_emitter: a reference model queues the expected
// characters and read addresses, monitors pop and compare them.
module tb_srec_emitter;

  localparam int BPR = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        dumpEnable = 1'b0;
  logic [31:0] dumpStartAddr = '0;
  logic [31:0] dumpLength = '0;
  logic [31:0] dumpEntryAddr = '0;
  logic        dumpBusy;
  logic        dumpDone;

  srec_emitter_if bus();

  srec_emitter #(.BYTES_PER_REC(BPR)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .dumpEnable(dumpEnable),
    .dumpStartAddr(dumpStartAddr),
    .dumpLength(dumpLength),
    .dumpEntryAddr(dumpEntryAddr),
    .dumpBusy(dumpBusy),
    .dumpDone(dumpDone),
    .bus(bus)
  );

  always #5 clock = ~clock;

  logic [7:0]  expChars[$];
  logic [31:0] expReads[$];
  logic [7:0]  rxLog[$];
  int checks = 0;
  int errors = 0;
  int charIdx = 0;
  int busyCycles = 0;
  int readCount = 0;
  int readyMode = 0;
  int stallLeft = 0;
  logic       stalledPrev = 1'b0;
  logic [7:0] stalledChar = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Memory contents are a fixed function of the address; upper data bits carry junk.
  function automatic logic [7:0] memByte(input logic [31:0] a);
    return a[7:0] + a[15:8] + 8'd1;
  endfunction

  always @(posedge clock)
    if (bus.memReadEn) bus.memData <= {24'hA5C3E1, memByte(bus.memAddr)};

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic pushHex(input logic [7:0] b);
    expChars.push_back(hexChar(b[7:4]));
    expChars.push_back(hexChar(b[3:0]));
  endtask

  task automatic buildExpected(input logic [31:0] startAddr, input logic [31:0] len, input logic [31:0] entry);
    logic [31:0] addr;
    logic [31:0] rem;
    logic [7:0]  sum;
    logic [7:0]  d;
    int n;
    addr = startAddr;
    rem  = len;
    expChars.delete();
    expReads.delete();
    while (rem != 0) begin
      n = (rem < 32'(BPR)) ? int'(rem) : BPR;
      expChars.push_back(8'h53);
      expChars.push_back(8'h33);
      sum = 8'(n + 5);
      pushHex(sum);
      for (int k = 3; k >= 0; k--) begin
        pushHex(addr[8*k +: 8]);
        sum = sum + addr[8*k +: 8];
      end
      for (int i = 0; i < n; i++) begin
        d = memByte(addr + 32'(i));
        expReads.push_back(addr + 32'(i));
        pushHex(d);
        sum = sum + d;
      end
      pushHex(~sum);
      expChars.push_back(8'h0A);
      addr = addr + 32'(n);
      rem  = rem - 32'(n);
    end
    expChars.push_back(8'h53);
    expChars.push_back(8'h37);
    pushHex(8'h05);
    sum = 8'h05;
    for (int k = 3; k >= 0; k--) begin
      pushHex(entry[8*k +: 8]);
      sum = sum + entry[8*k +: 8];
    end
    pushHex(~sum);
    expChars.push_back(8'h0A);
  endtask

  // Character, read-address and stall-stability monitor.
  always @(negedge clock) begin
    if (!reset_n) begin
      stalledPrev = 1'b0;
    end else begin
      if (dumpBusy) busyCycles++;
      if (stalledPrev) begin
        checkOutput("stallValid", {31'h0, bus.charValid}, 32'h1);
        checkOutput("stallChar", {24'h0, bus.charOut}, {24'h0, stalledChar});
      end
      stalledPrev = bus.charValid && !bus.charReady;
      stalledChar = bus.charOut;
      if (bus.charValid && bus.charReady) begin
        rxLog.push_back(bus.charOut);
        charIdx++;
        if (expChars.size() == 0) checkOutput("unexpectedChar", {24'h0, bus.charOut}, 32'hFFFFFFFF);
        else checkOutput("char", {24'h0, bus.charOut}, {24'h0, expChars.pop_front()});
      end
      if (bus.memReadEn) begin
        readCount++;
        checkOutput("accessSize", {30'h0, bus.memAccessSize}, 32'h0);
        if (expReads.size() == 0) checkOutput("unexpectedRead", 32'(expReads.size()), 32'h1);
        else checkOutput("readAddr", bus.memAddr, expReads.pop_front());
      end
    end
  end

  // Sink readiness: always ready, or a 3-cycle stall on an address char then random.
  initial begin
    bus.charReady = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (readyMode == 0) bus.charReady = 1'b1;
      else if (charIdx == 6 && stallLeft > 0) begin
        bus.charReady = 1'b0;
        stallLeft--;
      end else if (charIdx >= 12) bus.charReady = ($urandom_range(0, 1) == 1);
      else bus.charReady = 1'b1;
    end
  end

  task automatic applyStimulus(input logic [31:0] startAddr, input logic [31:0] len, input logic [31:0] entry);
    dumpStartAddr = startAddr;
    dumpLength    = len;
    dumpEntryAddr = entry;
    buildExpected(startAddr, len, entry);
    rxLog.delete();
    charIdx    = 0;
    busyCycles = 0;
    readCount  = 0;
    @(posedge clock);
    #1 dumpEnable = 1'b1;
    @(posedge clock);
    #1 dumpEnable = 1'b0;
    checkOutput("startBusyDone", {30'h0, dumpBusy, dumpDone}, 32'h2);
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while (dumpDone !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput({tag, "Done"}, {31'h0, dumpDone}, 32'h1);
    checkOutput({tag, "CharsLeft"}, 32'(expChars.size()), 32'h0);
    checkOutput({tag, "ReadsLeft"}, 32'(expReads.size()), 32'h0);
  endtask

  task automatic checkLiteral(input string tag, input string exp);
    int bad;
    bad = -1;
    if (rxLog.size() != exp.len()) bad = exp.len();
    else
      for (int i = 0; i < exp.len(); i++)
        if (bad < 0 && rxLog[i] != exp[i]) bad = i;
    checkOutput(tag, 32'(bad), 32'hFFFFFFFF);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("resetCtl", {28'h0, bus.charValid, bus.memReadEn, dumpBusy, dumpDone}, 32'h0);
    checkOutput("resetChar", {24'h0, bus.charOut}, 32'h0);
    checkOutput("resetAddr", bus.memAddr, 32'h0);
    reset_n = 1'b1;

    applyStimulus(32'h0000_0000, 32'd4, 32'h0000_0000);
    waitDone("single", 200);
    checkLiteral("singleText", "S3090000000001020304EC\nS70500000000FA\n");
    checkOutput("singleCycles", 32'(busyCycles), 32'd46);
    checkOutput("singleReads", 32'(readCount), 32'd4);
    repeat (5) @(negedge clock);
    checkOutput("doneSticky", {30'h0, dumpBusy, dumpDone}, 32'h1);

    applyStimulus(32'h0000_1000, 32'd20, 32'h1234_5678);
    waitDone("split", 400);
    checkOutput("splitCycles", 32'(busyCycles), 32'd125);

    applyStimulus(32'h0000_0000, 32'd0, 32'h8002_0000);
    waitDone("zero", 100);
    checkLiteral("zeroText", "S7058002000078\n");
    checkOutput("zeroReads", 32'(readCount), 32'd0);
    checkOutput("zeroCycles", 32'(busyCycles), 32'd15);

    readyMode = 1;
    stallLeft = 3;
    applyStimulus(32'h0000_1000, 32'd20, 32'h1234_5678);
    waitDone("stall", 2000);
    readyMode = 0;
    checkOutput("stallsUsed", 32'(stallLeft), 32'd0);

    applyStimulus(32'hFFFF_FFFE, 32'd4, 32'h0000_0000);
    waitDone("wrap", 200);
    checkLiteral("wrapText", "S309FFFFFFFEFEFF0102FB\nS70500000000FA\n");

    // Retrigger while busy must not disturb the stream, then reset mid-DATA.
    applyStimulus(32'h0000_2000, 32'd20, 32'h0000_0100);
    n = 0;
    while (charIdx < 4 && n < 100) begin
      @(negedge clock);
      #1 n++;
    end
    dumpStartAddr = 32'h5555_0000;
    dumpLength    = 32'd3;
    @(posedge clock);
    #1 dumpEnable = 1'b1;
    @(posedge clock);
    #1 dumpEnable = 1'b0;
    n = 0;
    while (charIdx < 13 && n < 200) begin
      @(negedge clock);
      #1 n++;
    end
    checkOutput("reachData", 32'(charIdx >= 13), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("midResetCtl", {28'h0, bus.charValid, bus.memReadEn, dumpBusy, dumpDone}, 32'h0);
    checkOutput("midResetChar", {24'h0, bus.charOut}, 32'h0);
    checkOutput("midResetAddr", bus.memAddr, 32'h0);
    expChars.delete();
    expReads.delete();
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("idleAfterReset", {30'h0, bus.charValid, dumpBusy}, 32'h0);

    applyStimulus(32'h0000_2000, 32'd20, 32'h0000_0100);
    waitDone("restart", 400);
    checkOutput("restartCycles", 32'(busyCycles), 32'd125);
    checkOutput("restartReads", 32'(readCount), 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
